// File: rtl/stream_mux_rr_if.sv
// Bundle of N input streams, the arbitration override and the single output stream of stream_mux_rr.
interface stream_mux_rr_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_last;
  logic [CHANNELS-1:0]       in_ready;
  logic                      force_en;
  logic [SEL_W-1:0]          force_sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, in_last, force_en, force_sel, out_ready,
    output in_ready, out_data, out_sel, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, force_en, force_sel, out_ready,
    input  in_ready, out_data, out_sel, out_last, out_valid
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with round-robin or fixed-priority arbitration,
// packet locking on in_last and a single registered output stage.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  stream_mux_rr_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int unsigned NCH = CHANNELS;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_next;
  logic [SEL_W-1:0] lock_ch, rr_ptr, grant, next_ptr;
  logic             grant_vld, load_ok, accept, grant_last, found;
  int unsigned      idx;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    found     = 1'b0;
    idx       = 0;
    if (state == LOCKED) begin
      grant     = lock_ch;
      grant_vld = bus.in_valid[lock_ch];
    end else if (bus.force_en) begin
      grant = bus.force_sel;
      if (32'(bus.force_sel) < NCH)
        grant_vld = bus.in_valid[bus.force_sel];
    end else begin
      // Scan starts at rr_ptr for round-robin, at channel 0 for fixed priority.
      for (int unsigned i = 0; i < NCH; i++) begin
        idx = (MODE == 0) ? (32'(rr_ptr) + i) % NCH : i;
        if (!found && bus.in_valid[idx]) begin
          found = 1'b1;
          grant = SEL_W'(idx);
        end
      end
      grant_vld = found;
    end
  end

  // reset_n gates acceptance so no channel sees ready while reset is held.
  assign load_ok    = !bus.out_valid || bus.out_ready;
  assign accept     = reset_n && load_ok && grant_vld;
  assign grant_last = bus.in_last[grant];
  assign next_ptr   = (32'(grant) == NCH - 1) ? '0 : grant + 1'b1;

  always_comb begin
    bus.in_ready = '0;
    for (int unsigned i = 0; i < NCH; i++)
      bus.in_ready[i] = accept && (32'(grant) == i);
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      if (state == IDLE && !grant_last)
        state_next = LOCKED;
      else if (state == LOCKED && grant_last)
        state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      lock_ch       <= '0;
      rr_ptr        <= '0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      bus.out_last  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (state == IDLE)
          lock_ch <= grant;
        if (grant_last)
          rr_ptr <= next_ptr;
        bus.out_data  <= bus.in_data[32'(grant)*WIDTH +: WIDTH];
        bus.out_sel   <= grant;
        bus.out_last  <= grant_last;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule
